return_stack: RTL and testbench

RETURN_STACK -- requirements
Module: return_stack

---
 rtl/return_stack.sv | 85 ++++++++
 tb/tb_return_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Return-address stack for call/return prediction: circular buffer with
// wrap-on-overflow and pointer/occupancy checkpoint recovery.
module return_stack #(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              recover,
    input  logic [PTR_W-1:0]  recover_ptr,
    input  logic [CNT_W-1:0]  recover_cnt,
    output logic              top_valid,
    output logic [ADDR_W-1:0] top_addr,
    output logic [PTR_W-1:0]  ckpt_ptr,
    output logic [CNT_W-1:0]  ckpt_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  tos, tos_nxt, wr_ptr;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wr_en, ovf_nxt, unf_nxt;

    always_comb begin
        tos_nxt = tos;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_ptr  = tos;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (recover) begin
            tos_nxt = recover_ptr;
            cnt_nxt = (recover_cnt > FULL) ? FULL : recover_cnt;
        end else if (push && pop && cnt != '0) begin
            // simultaneous call/return replaces the top in place
            wr_en = 1'b1;
        end else if (push) begin
            tos_nxt = tos + PTR_W'(1);
            wr_ptr  = tos + PTR_W'(1);
            wr_en   = 1'b1;
            if (cnt == FULL) ovf_nxt = 1'b1;
            else             cnt_nxt = cnt + CNT_W'(1);
        end else if (pop) begin
            if (cnt == '0) begin
                unf_nxt = 1'b1;
            end else begin
                tos_nxt = tos - PTR_W'(1);
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tos       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_nxt;
            cnt       <= cnt_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    // storage is not reset, but writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (resetn && wr_en) mem[wr_ptr] <= push_addr;
    end

    assign top_valid = (cnt != '0);
    assign top_addr  = mem[tos];
    assign ckpt_ptr  = tos;
    assign ckpt_cnt  = cnt;

endmodule

// File: tb/tb_return_stack.sv
// Randomized and directed bench for return_stack (DEPTH=4) against a
// behavioural stack model.
module tb_return_stack;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        push = 1'b0, pop = 1'b0, recover = 1'b0;
    logic [31:0] push_addr = '0;
    logic [1:0]  recover_ptr = '0;
    logic [2:0]  recover_cnt = '0;
    logic        top_valid, overflow, underflow;
    logic [31:0] top_addr;
    logic [1:0]  ckpt_ptr;
    logic [2:0]  ckpt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_tos, m_cnt;
    bit          m_ovf, m_unf;

    return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .push(push), .push_addr(push_addr),
        .pop(pop), .recover(recover), .recover_ptr(recover_ptr),
        .recover_cnt(recover_cnt), .top_valid(top_valid), .top_addr(top_addr),
        .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void model_step(bit p, logic [31:0] a, bit po, bit r, int rp, int rc);
        m_ovf = 0; m_unf = 0;
        if (r) begin
            m_tos = rp;
            m_cnt = (rc < DEPTH) ? rc : DEPTH;
        end else if (p && po && m_cnt > 0) begin
            m_mem[m_tos] = a; m_known[m_tos] = 1;
        end else if (p) begin
            m_tos = (m_tos + 1) % DEPTH;
            m_mem[m_tos] = a; m_known[m_tos] = 1;
            if (m_cnt == DEPTH) m_ovf = 1;
            else m_cnt++;
        end else if (po) begin
            if (m_cnt == 0) m_unf = 1;
            else begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(top_valid), 32'(m_cnt != 0));
        check({tag, ".ptr"},   32'(ckpt_ptr),  32'(m_tos));
        check({tag, ".cnt"},   32'(ckpt_cnt),  32'(m_cnt));
        check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(underflow), 32'(m_unf));
        if (m_cnt > 0 && m_known[m_tos])
            check({tag, ".top"}, top_addr, m_mem[m_tos]);
    endtask

    // drive one operation, clock it, update the model and compare
    task automatic op(input string tag, input bit p, input logic [31:0] a, input bit po,
                      input bit r = 0, input int rp = 0, input int rc = 0);
        push = p; push_addr = a; pop = po; recover = r;
        recover_ptr = 2'(rp); recover_cnt = 3'(rc);
        @(posedge clk);
        model_step(p, a, po, r, rp, rc);
        #1;
        push = 0; pop = 0; recover = 0;
        check_all(tag);
    endtask

    task automatic do_reset();
        resetn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;
        model_reset();
    endtask

    int sp, sc;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        resetn = 1;

        // LIFO order, then drain to empty
        op("p1", 1, 32'h100, 0); op("p2", 1, 32'h200, 0); op("p3", 1, 32'h300, 0);
        check("lifo_top0", top_addr, 32'h300);
        op("q1", 0, 0, 1); check("lifo_top1", top_addr, 32'h200);
        op("q2", 0, 0, 1); check("lifo_top2", top_addr, 32'h100);
        op("q3", 0, 0, 1);
        check("drained_valid", 32'(top_valid), 32'd0);
        check("drained_unf", 32'(underflow), 32'd0);

        // overflow wraps onto the oldest entry
        for (int i = 1; i <= 5; i++) op("ovp", 1, 32'(i * 16), 0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_cnt", 32'(ckpt_cnt), 32'd4);
        op("ovi", 0, 0, 0);
        check("ovf_once", 32'(overflow), 32'd0);
        for (int i = 5; i >= 2; i--) begin
            check("ovf_top", top_addr, 32'(i * 16));
            op("ovq", 0, 0, 1);
        end

        // pop while empty
        op("uf", 0, 0, 1);
        check("uf_pulse", 32'(underflow), 32'd1);
        check("uf_cnt", 32'(ckpt_cnt), 32'd0);
        op("uf_idle", 0, 0, 0);
        check("uf_once", 32'(underflow), 32'd0);

        // push+pop on empty acts as a plain push
        op("pp_empty", 1, 32'h77, 1);
        check("pp_empty_cnt", 32'(ckpt_cnt), 32'd1);
        op("pp_drain", 0, 0, 1);

        // replace top
        op("ra", 1, 32'hA0, 0); op("rb", 1, 32'hB0, 0);
        op("rc", 1, 32'hC0, 1);
        check("repl_top", top_addr, 32'hC0);
        check("repl_cnt", 32'(ckpt_cnt), 32'd2);
        op("rq", 0, 0, 1);
        check("repl_below", top_addr, 32'hA0);
        op("rq2", 0, 0, 1);

        // checkpoint, speculate, recover (push in the same cycle is ignored)
        op("ka", 1, 32'hA0, 0); op("kb", 1, 32'hB0, 0);
        sp = int'(ckpt_ptr); sc = int'(ckpt_cnt);
        op("kc", 1, 32'hC0, 0); op("kq1", 0, 0, 1); op("kq2", 0, 0, 1);
        op("krec", 1, 32'hDEAD, 0, 1, sp, sc);
        check("rec_top", top_addr, 32'hB0);
        check("rec_cnt", 32'(ckpt_cnt), 32'd2);
        // recovery count saturates at DEPTH
        op("krec_sat", 0, 0, 1, 1, 3, 7);
        check("rec_sat", 32'(ckpt_cnt), 32'd4);

        // asynchronous reset between edges
        do_reset();
        op("ar1", 1, 32'h1, 0); op("ar2", 1, 32'h2, 0); op("ar3", 1, 32'h3, 0);
        #2 resetn = 0;
        #1;
        model_reset();
        check("async_valid", 32'(top_valid), 32'd0);
        check("async_cnt", 32'(ckpt_cnt), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        check("async_unf", 32'(underflow), 32'd0);
        push = 1; push_addr = 32'h55;
        @(posedge clk); #1;
        check_all("rst_push_discard");
        push = 0;
        @(negedge clk);
        resetn = 1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 15) == 0);
            op("rnd", 1'($urandom), $urandom, 1'($urandom), r,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
